// File: rtl/aes_pkg.sv
// Shared AES package: block/round constants, FSM state type for the iterative
// encryptor, and the GF(2^8) helpers and forward S-box used by its round logic.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_AES128   = 10;

  // Encryptor control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  // Multiply by x (i.e. by 2) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (addition chain); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  // Forward S-box: field inverse followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (when sel_mix_col) -> AddRoundKey.
// Ports:
//   state_in    128  current state, bits [127:120] = byte 0, column-major
//   round_key   128  key added at the end of the round
//   sel_mix_col 1    apply MixColumns (low for the final round)
//   state_out   128  next state, same byte order
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   sel_mix_col,
  output logic [AES_BLOCK_W-1:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = '0;
      sr[i] = '0;
      mc[i] = '0;
    end
    state_out = '0;

    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[AES_BLOCK_W-1-8*i -: 8]);
    end

    // Byte index i = 4*col + row; row r rotates left by r columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end

    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c+0] = gf_mul2(sr[4*c+0]) ^ gf_mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ gf_mul2(sr[4*c+1]) ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ gf_mul2(sr[4*c+2]) ^ gf_mul3(sr[4*c+3]);
      mc[4*c+3] = gf_mul3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
    end

    for (int unsigned i = 0; i < 16; i++) begin
      state_out[AES_BLOCK_W-1-8*i -: 8] = (sel_mix_col ? mc[i] : sr[i]) ^
                                          round_key[AES_BLOCK_W-1-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_iterative_encrypt.sv
// Iterative AES encryptor: one round engine reused for NR rounds per block,
// with valid/ready handshakes on plaintext and ciphertext sides.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_ready, plaintext      input block handshake (ready only in IDLE)
//   round_keys_flat  rk[k] = round_keys_flat[k*128 +: 128]; must stay stable
//                    from acceptance until handoff (not latched here)
//   out_valid/out_ready, ciphertext   output block handshake (held until taken)
module aes_iterative_encrypt
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [AES_BLOCK_W-1:0]          plaintext,
  input  logic [(NR+1)*AES_BLOCK_W-1:0]   round_keys_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [AES_BLOCK_W-1:0]          ciphertext
);

  localparam int RND_W = $clog2(NR + 1);

  aes_fsm_e               state_q, state_d;
  logic [RND_W-1:0]       rnd_q;
  logic [AES_BLOCK_W-1:0] state_reg;
  logic [AES_BLOCK_W-1:0] round_key;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   last_round;
  logic                   accept;
  logic                   handoff;

  // Key mux; counter values past NR (only seen in DONE) select zero.
  always_comb begin
    round_key = '0;
    for (int unsigned k = 0; k < NR + 1; k++) begin
      if (rnd_q == RND_W'(k)) round_key = round_keys_flat[k*AES_BLOCK_W +: AES_BLOCK_W];
    end
  end

  assign last_round = (rnd_q == RND_W'(NR));

  aes_enc_round u_round (
    .state_in    (state_reg),
    .round_key   (round_key),
    .sel_mix_col (!last_round),
    .state_out   (round_out)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    handoff = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (last_round) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          handoff = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      state_reg <= '0;
      rnd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        state_reg <= plaintext ^ round_keys_flat[AES_BLOCK_W-1:0];
        rnd_q     <= RND_W'(1);
      end else if (state_q == ST_ROUND) begin
        state_reg <= round_out;
        rnd_q     <= rnd_q + 1'b1;
      end else if (handoff) begin
        rnd_q <= '0;
      end
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign ciphertext = out_valid ? state_reg : '0;

endmodule

// File: tb/tb_aes_iterative_encrypt.sv
module tb_aes_iterative_encrypt;
  localparam int NR = 10;
  localparam int KW = (NR + 1) * 128;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  plaintext;
  logic [KW-1:0] round_keys_flat;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  ciphertext;

  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  aes_iterative_encrypt #(.NR(NR)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .plaintext       (plaintext),
    .round_keys_flat (round_keys_flat),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .ciphertext      (ciphertext)
  );

  // ---------------- reference AES (table S-box, 4x4 byte matrix) ----------
  logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [127:0] row;
    row = SBOX_ROWS[x[7:4]];
    return row[8*(15 - int'(x[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] tb_xt(input logic [7:0] x);
    return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
  endfunction

  function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [4*(NR+1)];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [KW-1:0] res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {tb_sbox(t[23:16]) ^ rcon, tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])};
        rcon = tb_xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++) res[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return res;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [KW-1:0] rks);
    logic [7:0]   st  [4][4];
    logic [7:0]   tmp [4][4];
    logic [127:0] rk;
    logic [127:0] res;
    rk = rks[127:0];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= NR; rd++) begin
      rk = rks[rd*128 +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = tb_sbox(st[r][(c+r)%4]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rd < NR)
            st[r][c] = tb_xt(tmp[r][c]) ^ tb_xt(tmp[(r+1)%4][c]) ^ tmp[(r+1)%4][c] ^
                       tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
          else
            st[r][c] = tmp[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          st[r][c] = st[r][c] ^ rk[127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- cycle-level behavioural model ---------------------------
  bit           m_live  = 1'b0;
  bit           m_ready = 1'b0;
  bit           m_valid = 1'b0;
  int           m_cnt   = 0;
  logic [127:0] m_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_live  <= 1'b1;
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_cnt   <= 0;
    end else if (m_live) begin
      if (m_ready && in_valid) begin
        m_ready <= 1'b0;
        m_pend  <= model_encrypt(plaintext, round_keys_flat);
        m_cnt   <= NR;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_valid <= 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", {127'd0, in_ready}, {127'd0, m_ready});
      check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
      if (m_valid) check("ciphertext", ciphertext, m_pend);
    end
  end

  // ---------------- directed + random stimulus -----------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 128'd0, 128'd1);
  endtask

  logic [127:0] got_q [$];
  int           n;
  bit           second;
  bit           rdy;
  bit           ov;
  bit           acc;
  logic [127:0] ct_s;
  logic [KW-1:0] kb, kc;

  initial begin
    kb = expand_key(KEY_B);
    kc = expand_key(KEY_C);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; round_keys_flat = kb;

    // model pinned to FIPS-197 vectors
    check("model_appB", model_encrypt(PT_B, kb), CT_B);
    check("model_appC1", model_encrypt(PT_C, kc), CT_C);
    check("model_rk10_appB", kb[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    tick();
    rst = 1'b0;
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_ciphertext", ciphertext, 128'd0);

    // App. B with latency measurement and backpressure
    plaintext = PT_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; plaintext = $urandom();
    wait_valid("appB", n);
    check("appB_latency", 128'(n), 128'd10);
    check("appB_ct", ciphertext, CT_B);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_ct", ciphertext, CT_B);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_handoff_out_valid", {127'd0, out_valid}, 128'd0);
    check("post_handoff_in_ready", {127'd0, in_ready}, 128'd1);

    // back-to-back: App. B then App. C.1 with in_valid held
    got_q.delete();
    plaintext = PT_B; round_keys_flat = kb; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    plaintext = PT_C;
    n = 0; second = 1'b0;
    for (int i = 0; i < 40 && !second; i++) begin
      rdy = in_ready; ov = out_valid; ct_s = ciphertext;
      tick();
      n++;
      if (ov) begin
        got_q.push_back(ct_s);
        round_keys_flat = kc;
      end
      if (rdy) begin
        second = 1'b1;
        in_valid = 1'b0;
      end
    end
    check("b2b_spacing", 128'(n), 128'd12);
    wait_valid("b2b_second", n);
    got_q.push_back(ciphertext);
    tick();
    out_ready = 1'b0;
    check("b2b_count", 128'(got_q.size()), 128'd2);
    if (got_q.size() == 2) begin
      check("b2b_first", got_q[0], CT_B);
      check("b2b_second", got_q[1], CT_C);
    end

    // in_valid pulsed during ROUND is ignored
    round_keys_flat = kc; plaintext = PT_C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1; plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    in_valid = 1'b0;
    wait_valid("ignored", n);
    check("ignored_ct", ciphertext, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset mid-round discards the block
    round_keys_flat = kb; plaintext = PT_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("midrst_no_output", 128'(n), 128'd0);
    round_keys_flat = kc; plaintext = PT_C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("after_rst", n);
    check("after_rst_ct", ciphertext, CT_C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // randomized traffic, key changed only while drained
    for (int b = 0; b < 3; b++) begin
      round_keys_flat = expand_key({$urandom(), $urandom(), $urandom(), $urandom()});
      for (int i = 0; i < 200; i++) begin
        acc = in_valid && in_ready;
        tick();
        if (!in_valid || acc) begin
          in_valid  = 1'($urandom_range(0, 1));
          plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (15) tick();
      out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/aes_iterative_encrypt.md
Name: aes_iterative_encrypt

Overview:
AES-128 encryptor built on one iterative round engine, reused across NR+1 clock cycles per block. It is the encrypt-direction counterpart of the pipelined decryptor. It takes the same flat round-key bus, ordered rk[0..NR], produced by the shared key-expansion logic. It sits between the UART RX byte assembler (plaintext source) and the UART TX serializer (ciphertext sink), so it carries a valid/ready handshake on both sides.

Parameters:
NR, 10, number of AES rounds; 10 for AES-128, and the only value verified.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  plaintext valid
in_ready  out  1  block can accept a plaintext this cycle
plaintext  in  128  input block; bits [127:120] = FIPS byte 0 (column-major state)
round_keys_flat  in  (NR+1)*128  rk[k] = round_keys_flat[k*128 +: 128]; rk[0] is the cipher key
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts ciphertext
ciphertext  out  128  result block, same byte order as plaintext

Behaviour:
- Reset: synchronous, active-high, one clock.
  - After the first rising edge with rst=1: FSM=IDLE, in_ready=1, out_valid=0, ciphertext=0, round counter=0.
  - rst mid-operation discards the block in flight; nothing is emitted for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: state_reg <= plaintext ^ rk[0], rnd <= 1, go to ROUND.
  - ROUND: in_ready=0. Each edge, state_reg <= enc_round(state_reg, rk[rnd]) and rnd <= rnd+1.
    - MixColumns is applied only when rnd != NR.
    - When rnd==NR, that edge applies the final round and moves to DONE.
  - DONE: out_valid=1 and ciphertext=state_reg, both held stable until out_ready=1. On out_valid&&out_ready, go to IDLE.
- Latency:
  - Acceptance edge T; final round at edge T+NR; out_valid first high in the cycle after edge T+NR.
  - For NR=10, ciphertext is available 10 cycles after acceptance.
- Throughput: one block per NR+2 cycles minimum (accept, NR rounds, handoff).
- Handshake rules:
  - in_ready is a registered state decode (IDLE only). It does not depend combinationally on in_valid or out_ready.
  - A new block is never accepted in the same cycle that DONE hands off. in_ready rises the cycle after the handoff.
  - in_valid while not ready is ignored; the source must hold its data.
  - out_ready held low keeps out_valid/ciphertext stable indefinitely, with no data loss.
  - out_ready asserted in IDLE or ROUND has no effect.
- Round keys: round_keys_flat must stay stable from the acceptance edge until the handoff; the block does not latch them. Key changes outside that window are legal.
- Round counter: ceil(log2(NR+1)) bits. It is never compared beyond NR and does not wrap in normal operation.
- Round datapath: SubBytes → ShiftRows → (MixColumns if enabled) → AddRoundKey, all in one cycle, combinational between state_reg and its next value.
- Simultaneous events: rst dominates in_valid and out_ready.

Decomposition:
- Shared package aes_pkg:
  - forward S-box function and xtime/GF(2^8) multiply-by-2/3 functions, shared with the decryptor's inverse functions;
  - AES_BLOCK_W=128 and NR_AES128=10;
  - FSM state encoding localparams for IDLE/ROUND/DONE.
- Sub-module aes_enc_round:
  - purely combinational;
  - ports state_in[127:0], round_key[127:0], sel_mix_col, state_out[127:0];
  - mirrors the decryptor's inverse-round interface without its pipeline stage.
- The top holds only the FSM, counter, state register and handshake.

Test Plan:
- Reset → in_ready=1, out_valid=0, ciphertext=0. Then FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c (bench-expanded), pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after acceptance.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → ciphertext stable and in_ready=0 throughout. Pulse out_ready → one transfer, out_valid=0 next cycle, in_ready=1 next cycle.
- Back-to-back: in_valid held high with the App. B then App. C.1 blocks and out_ready=1 → second acceptance exactly 12 cycles after the first; both ciphertexts correct and in order.
- Ignored input: in_valid pulsed with a different plaintext during ROUND → no effect; the in-flight result is unchanged.
- Reset mid-round: rst=1 at round 5 for one cycle → in_ready=1 and out_valid=0 after that edge, no output for that block. A following App. C.1 block encrypts correctly.
